// File: rtl/pipediv_stream.sv
// pipediv_stream: fully pipelined restoring divider with a valid/ready stream
// interface. One register stage per BITS_PER_STAGE quotient bits, MSB first;
// the whole pipeline advances together and freezes while the output is held.
// Optional build macro: PIPEDIV_SIGNED_EN adds the in_signed port and
// two's-complement division (quotient toward zero, remainder takes the
// dividend's sign).
module pipediv_stream #(
  parameter int DIVIDENDLEN    = 16,
  parameter int DIVISORLEN     = 8,
  parameter int BITS_PER_STAGE = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
`ifdef PIPEDIV_SIGNED_EN
  input  logic                   in_signed,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder,
  output logic                   div_by_zero
);

  localparam int NSTAGES = DIVIDENDLEN / BITS_PER_STAGE;
  // Wide enough to hold divisor << (DIVIDENDLEN-1), the largest trial value.
  localparam int PREMLEN = DIVIDENDLEN + DIVISORLEN - 1;

  generate
    if ((DIVIDENDLEN % BITS_PER_STAGE) != 0) begin : g_bad_cfg
      $error("pipediv_stream: BITS_PER_STAGE must divide DIVIDENDLEN");
    end
  endgenerate

  typedef struct packed {
    logic                   valid;
    logic [PREMLEN-1:0]     prem;
    logic [DIVISORLEN-1:0]  dvs;
    logic [DIVIDENDLEN-1:0] quo;
    logic                   dbz;
`ifdef PIPEDIV_SIGNED_EN
    logic                   neg_q;
    logic                   neg_r;
`endif
  } stage_t;

  // Resolve BITS_PER_STAGE quotient bits for stage idx. The partial remainder
  // is compared against the divisor aligned to the bit being resolved, so a
  // zero divisor always "fits": quotient goes all ones and the remainder keeps
  // the dividend untouched, which is exactly the divide-by-zero result.
  function automatic stage_t resolve(input stage_t cur, input int idx);
    stage_t             nxt;
    logic [PREMLEN-1:0] trial;
    int                 sh;
    nxt = cur;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      sh      = DIVIDENDLEN - 1 - idx * BITS_PER_STAGE - b;
      trial   = PREMLEN'(cur.dvs) << sh;
      nxt.quo = nxt.quo << 1;
      if (nxt.prem >= trial) begin
        nxt.prem   = nxt.prem - trial;
        nxt.quo[0] = 1'b1;
      end
    end
    return nxt;
  endfunction

  logic                   advance;
  logic [DIVIDENDLEN-1:0] a_mag;
  logic [DIVISORLEN-1:0]  b_mag;
  logic [DIVISORLEN-1:0]  rem_mag;
  stage_t                 entry;
  stage_t                 pipe_reg  [NSTAGES];
  stage_t                 pipe_next [NSTAGES];

  // The pipeline moves unless a finished result is waiting on the consumer.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Build the stage-0 operand record; signed operands enter as magnitudes and
  // the sign corrections ride along to the output.
  always_comb begin
    entry       = '0;
    a_mag       = dividend;
    b_mag       = divisor;
    entry.valid = in_valid && in_ready;
    entry.dbz   = (divisor == '0);
`ifdef PIPEDIV_SIGNED_EN
    entry.neg_r = in_signed && dividend[DIVIDENDLEN-1];
    entry.neg_q = (entry.neg_r ^ (in_signed && divisor[DIVISORLEN-1])) && !entry.dbz;
    if (entry.neg_r) begin
      a_mag = -dividend;
    end
    if (in_signed && divisor[DIVISORLEN-1]) begin
      b_mag = -divisor;
    end
`endif
    entry.prem = PREMLEN'(a_mag);
    entry.dvs  = b_mag;
  end

  assign pipe_next[0] = resolve(entry, 0);

  generate
    for (genvar gi = 1; gi < NSTAGES; gi++) begin : g_stage
      assign pipe_next[gi] = resolve(pipe_reg[gi-1], gi);
    end
  endgenerate

  // Stage registers: cleared asynchronously, shifted together on advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSTAGES; s++) begin
        pipe_reg[s] <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < NSTAGES; s++) begin
        pipe_reg[s] <= pipe_next[s];
      end
    end
  end

  assign out_valid   = pipe_reg[NSTAGES-1].valid;
  assign div_by_zero = pipe_reg[NSTAGES-1].dbz;
  assign rem_mag     = pipe_reg[NSTAGES-1].prem[DIVISORLEN-1:0];

`ifdef PIPEDIV_SIGNED_EN
  assign quotient  = pipe_reg[NSTAGES-1].neg_q ? -pipe_reg[NSTAGES-1].quo
                                               :  pipe_reg[NSTAGES-1].quo;
  assign remainder = pipe_reg[NSTAGES-1].neg_r ? -rem_mag : rem_mag;
`else
  assign quotient  = pipe_reg[NSTAGES-1].quo;
  assign remainder = rem_mag;
`endif

endmodule

// File: tb/tb_pipediv_stream.sv
// tb_pipediv_stream: vector table, random streams with backpressure, and
// reset-in-flight sequences for pipediv_stream at default widths, run on a
// 1-bit-per-stage instance and a 4-bits-per-stage instance in parallel.
module tb_pipediv_stream;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_signed = 1'b0;
  logic [15:0] dividend  = '0;
  logic [7:0]  divisor   = '0;

  logic        in_ready, out_valid, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        in_ready4, out_valid4, dbz4;
  logic [15:0] q4;
  logic [7:0]  r4;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   streak = 0;
  int   max_streak = 0;
  int   seen_valid = 0;
  bit   chk_lat = 1'b0;
  exp_t cur_exp;
  exp_t sb0[$];
  exp_t sb1[$];
  vec_t vt[$];
  bit          prev_stall [2];
  logic [15:0] hold_q [2];
  logic [7:0]  hold_r [2];
  logic        hold_z [2];

  always #5 clock = ~clock;

  pipediv_stream dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
`ifdef PIPEDIV_SIGNED_EN
    .in_signed(in_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  pipediv_stream #(.BITS_PER_STAGE(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .dividend(dividend), .divisor(divisor),
`ifdef PIPEDIV_SIGNED_EN
    .in_signed(in_signed),
`endif
    .out_valid(out_valid4), .out_ready(out_ready),
    .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  // Reference: plain arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input logic sgn);
    exp_t e;
    int   ai, bi, qi, ri;
    e.acc = 0;
    e.lat = 1'b0;
    e.z   = (b == 8'd0);
    if (b == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
    end else if (sgn) begin
      ai  = int'($signed(a));
      bi  = int'($signed(b));
      qi  = ai / bi;
      ri  = ai % bi;
      e.q = qi[15:0];
      e.r = ri[7:0];
    end else begin
      e.q = a / 16'(b);
      e.r = 8'(a % 16'(b));
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle observation of one DUT at the falling edge.
  task automatic observe(input int d, input logic ov, input logic ir, input logic [15:0] q,
                         input logic [7:0] r, input logic z, input int nst);
    exp_t e;
    bit   empty;
    check($sformatf("in_ready_dut%0d", d), 32'(ir), 32'(!(ov && !out_ready)));
    if (prev_stall[d]) begin
      check($sformatf("held_valid_dut%0d", d), 32'(ov), 32'd1);
      check($sformatf("held_q_dut%0d", d), 32'(q), 32'(hold_q[d]));
      check($sformatf("held_r_dut%0d", d), 32'(r), 32'(hold_r[d]));
      check($sformatf("held_z_dut%0d", d), 32'(z), 32'(hold_z[d]));
    end
    prev_stall[d] = ov && !out_ready;
    hold_q[d] = q;
    hold_r[d] = r;
    hold_z[d] = z;
    if (ov && out_ready) begin
      empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_result_dut%0d: got q=%0h r=%0h required no result (cycle %0d)",
                 d, q, r, cyc);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        $display("dut%0d out q=%04h r=%02h z=%0b exp q=%04h r=%02h z=%0b", d, q, r, z, e.q, e.r, e.z);
        check($sformatf("quotient_dut%0d", d), 32'(q), 32'(e.q));
        check($sformatf("remainder_dut%0d", d), 32'(r), 32'(e.r));
        check($sformatf("dbz_dut%0d", d), 32'(z), 32'(e.z));
        if (e.lat) check($sformatf("latency_dut%0d", d), 32'(cyc - e.acc), 32'(nst));
      end
    end
    if (in_valid && ir) begin
      e     = cur_exp;
      e.acc = cyc;
      e.lat = chk_lat;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    observe(0, out_valid, in_ready, quotient, remainder, div_by_zero, 16);
    observe(1, out_valid4, in_ready4, q4, r4, dbz4, 4);
    if (out_valid) streak++;
    else streak = 0;
    if (streak > max_streak) max_streak = streak;
    if (out_valid || out_valid4) seen_valid++;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic rand_op();
    dividend = 16'($urandom);
    divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
`ifdef PIPEDIV_SIGNED_EN
    in_signed = 1'($urandom);
`else
    in_signed = 1'b0;
`endif
    cur_exp = model(dividend, divisor, in_signed);
  endtask

  task automatic apply_vec(input vec_t v);
    dividend  = v.a;
    divisor   = v.b;
    in_signed = v.s;
    cur_exp.q = v.q;
    cur_exp.r = v.r;
    cur_exp.z = v.z;
    in_valid  = 1'b1;
    tick();
  endtask

  initial begin
    vt.push_back('{16'd1000,  8'd7,    1'b0, 16'd142,  8'd6,    1'b0});
    vt.push_back('{16'hBEEF,  8'd0,    1'b0, 16'hFFFF, 8'hEF,   1'b1});
    vt.push_back('{16'd0,     8'd5,    1'b0, 16'd0,    8'd0,    1'b0});
    vt.push_back('{16'hFFFF,  8'd1,    1'b0, 16'hFFFF, 8'd0,    1'b0});
    vt.push_back('{16'hFFFF,  8'hFF,   1'b0, 16'd257,  8'd0,    1'b0});
    vt.push_back('{16'd5,     8'd9,    1'b0, 16'd0,    8'd5,    1'b0});
    vt.push_back('{16'hFFFF,  8'h80,   1'b0, 16'h01FF, 8'h7F,   1'b0});
    vt.push_back('{16'd12345, 8'd100,  1'b0, 16'd123,  8'd45,   1'b0});
    vt.push_back('{16'd0,     8'd0,    1'b0, 16'hFFFF, 8'd0,    1'b1});
    vt.push_back('{16'hFFF9,  8'd2,    1'b0, 16'h7FFC, 8'd1,    1'b0});
`ifdef PIPEDIV_SIGNED_EN
    vt.push_back('{16'hFFF9,  8'd2,    1'b1, 16'hFFFD, 8'hFF,   1'b0});
    vt.push_back('{16'h8000,  8'hFF,   1'b1, 16'h8000, 8'd0,    1'b0});
    vt.push_back('{16'd7,     8'hFE,   1'b1, 16'hFFFD, 8'd1,    1'b0});
    vt.push_back('{16'hFFF9,  8'd0,    1'b1, 16'hFFFF, 8'hF9,   1'b1});
    vt.push_back('{16'd100,   8'hF9,   1'b1, 16'hFFF2, 8'd2,    1'b0});
`endif
    cur_exp = model(16'd0, 8'd1, 1'b0);
    for (int k = 0; k < 2; k++) prev_stall[k] = 1'b0;

    // Asynchronous reset, checked between clock edges.
    #2 reset_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid4", 32'(out_valid4), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Vector table, back to back, with latency checks.
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) apply_vec(vt[i]);
    in_valid = 1'b0;
    repeat (20) tick();

    // 64 back-to-back random pairs: results on 64 consecutive cycles.
    streak     = 0;
    max_streak = 0;
    for (int i = 0; i < 64; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    check("stream_streak", 32'(max_streak), 32'd64);

    // Fill, hold the consumer off for 5 cycles, then release.
    chk_lat = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_op();
      tick();
    end
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;

    // Random acceptance and backpressure mix.
    for (int i = 0; i < 150; i++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();
    check("drain_dut0", 32'(sb0.size()), 32'd0);
    check("drain_dut1", 32'(sb1.size()), 32'd0);

    // Reset with 10 operations in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_reset_out_valid4", 32'(out_valid4), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_valid4", 32'(out_valid4), 32'd0);
    check("midreset_quotient4", 32'(q4), 32'd0);
    check("midreset_remainder4", 32'(r4), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) prev_stall[k] = 1'b0;
    tick();
    reset_n    = 1'b1;
    seen_valid = 0;
    repeat (20) tick();
    check("no_stale_results", 32'(seen_valid), 32'd0);

    // One operation after reset still completes with the full latency.
    apply_vec(vt[0]);
    in_valid = 1'b0;
    repeat (20) tick();
    check("final_drain_dut0", 32'(sb0.size()), 32'd0);
    check("final_drain_dut1", 32'(sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
